// File: rtl/hog_stream_pkg.sv
// rtl/hog_stream_pkg.sv - shared types and header layout for the HOG frame packer
package hog_stream_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PAD     = 2'd2,
        TRAILER = 2'd3
    } state_e;

    localparam logic [15:0] SYNC_DEFAULT = 16'hA55A;

    localparam int HDR_SYNC_MSB = 31;
    localparam int HDR_SYNC_LSB = 16;
    localparam int HDR_SEQ_MSB  = 15;
    localparam int HDR_SEQ_LSB  = 0;

    function automatic logic [31:0] build_header(input logic [15:0] sync, input logic [15:0] seq);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_SYNC_MSB:HDR_SYNC_LSB] = sync;
        hdr[HDR_SEQ_MSB:HDR_SEQ_LSB]   = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/hog_frame_packer_if.sv
// rtl/hog_frame_packer_if.sv - HLS-side and FIFO-side stream signals of the frame packer
interface hog_frame_packer_if;

    logic [31:0] in_din;
    logic        in_write;
    logic        in_full_n;
    logic        flush;
    logic [31:0] out_din;
    logic        out_wr_en;
    logic        out_full;

    modport slave (
        input  in_din, in_write, flush, out_full,
        output in_full_n, out_din, out_wr_en
    );

    modport master (
        output in_din, in_write, flush, out_full,
        input  in_full_n, out_din, out_wr_en
    );

endinterface

// File: rtl/hog_frame_packer.sv
// rtl/hog_frame_packer.sv - wraps the HLS word stream into header/payload/checksum frames
module hog_frame_packer
    import hog_stream_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [15:0] SYNC      = SYNC_DEFAULT,
    parameter logic [31:0] PAD_WORD  = 32'h0000_0000
) (
    input  logic               bus_clk,
    input  logic               srst,
    hog_frame_packer_if.slave  bus,
    output logic [15:0]        frame_seq,
    output logic               busy,
    output logic               pad_event
);

    localparam int              IDLE_W    = $clog2(TIMEOUT) + 1;
    localparam logic [15:0]     LAST_CNT  = 16'(FRAME_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = {IDLE_W{1'b1}};

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [31:0]        csum_q, csum_d;
    logic [15:0]        frame_seq_q, frame_seq_d;
    logic               flush_pend_q, flush_pend_d;
    logic               pad_event_q, pad_event_d;

    logic [31:0]        out_din_c;
    logic               out_wr_en_c;
    logic               in_full_n_c;
    logic               xfer;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idle_cnt_d   = idle_cnt_q;
        csum_d       = csum_q;
        frame_seq_d  = frame_seq_q;
        flush_pend_d = flush_pend_q;
        pad_event_d  = 1'b0;
        out_din_c    = PAD_WORD;
        out_wr_en_c  = 1'b0;
        in_full_n_c  = 1'b0;
        xfer         = 1'b0;

        case (state_q)
            IDLE: begin
                out_din_c = build_header(SYNC, frame_seq_q);
                if (bus.in_write && !bus.out_full) begin
                    out_wr_en_c  = 1'b1;
                    state_d      = PAYLOAD;
                    cnt_d        = 16'd0;
                    csum_d       = 32'd0;
                    idle_cnt_d   = '0;
                    flush_pend_d = 1'b0;
                end
            end
            PAYLOAD: begin
                in_full_n_c = !bus.out_full;
                out_din_c   = bus.in_din;
                xfer        = bus.in_write && !bus.out_full;
                out_wr_en_c = xfer;
                if (xfer) begin
                    csum_d     = csum_q ^ bus.in_din;
                    cnt_d      = cnt_q + 16'd1;
                    idle_cnt_d = '0;
                    // A flush that loses to a transfer is remembered, unless the frame just closed.
                    if (cnt_q == LAST_CNT) begin
                        state_d      = TRAILER;
                        flush_pend_d = 1'b0;
                    end else if (bus.flush) begin
                        flush_pend_d = 1'b1;
                    end
                end else begin
                    if (idle_cnt_q != IDLE_MAX) begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                    if (bus.flush || flush_pend_q || idle_cnt_q == IDLE_LAST) begin
                        state_d      = PAD;
                        pad_event_d  = 1'b1;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            PAD: begin
                out_din_c = PAD_WORD;
                if (!bus.out_full) begin
                    out_wr_en_c = 1'b1;
                    csum_d      = csum_q ^ PAD_WORD;
                    cnt_d       = cnt_q + 16'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                out_din_c = csum_q;
                if (!bus.out_full) begin
                    out_wr_en_c = 1'b1;
                    frame_seq_d = frame_seq_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Nothing may reach the FIFO or be taken from HLS while the host has the device closed.
        if (srst) begin
            out_wr_en_c = 1'b0;
            in_full_n_c = 1'b0;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            idle_cnt_q   <= '0;
            csum_q       <= 32'd0;
            frame_seq_q  <= 16'd0;
            flush_pend_q <= 1'b0;
            pad_event_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            csum_q       <= csum_d;
            frame_seq_q  <= frame_seq_d;
            flush_pend_q <= flush_pend_d;
            pad_event_q  <= pad_event_d;
        end
    end

    assign bus.out_din   = out_din_c;
    assign bus.out_wr_en = out_wr_en_c;
    assign bus.in_full_n = in_full_n_c;
    assign frame_seq     = frame_seq_q;
    assign busy          = (state_q != IDLE);
    assign pad_event     = pad_event_q;

endmodule

// File: tb/tb_hog_frame_packer.sv
// tb/tb_hog_frame_packer.sv - directed table-driven bench for hog_frame_packer
module tb_hog_frame_packer;

    localparam int FL = 4;
    localparam int TO = 8;

    logic        bus_clk = 1'b0;
    logic        srst;
    logic [15:0] frame_seq;
    logic        busy;
    logic        pad_event;

    hog_frame_packer_if bus ();

    hog_frame_packer #(
        .FRAME_LEN (FL),
        .TIMEOUT   (TO),
        .SYNC      (16'hA55A),
        .PAD_WORD  (32'h0000_0000)
    ) dut (
        .bus_clk   (bus_clk),
        .srst      (srst),
        .bus       (bus),
        .frame_seq (frame_seq),
        .busy      (busy),
        .pad_event (pad_event)
    );

    always #5 bus_clk = ~bus_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        int               n;
        logic [3:0][31:0] w;
        int               flush_idx;
        int               stall_at;
        int               stall_len;
        logic [4:0][31:0] exp;
        int               exp_pad;
        int               exp_gap;
    } row_t;

    function automatic row_t mk(input int n, input logic [31:0] w0, w1, w2, w3,
                                input int fi, sa, sl,
                                input logic [31:0] e0, e1, e2, e3, e4,
                                input int pad, gap);
        row_t r;
        r.n = n;
        r.w[0] = w0; r.w[1] = w1; r.w[2] = w2; r.w[3] = w3;
        r.flush_idx = fi; r.stall_at = sa; r.stall_len = sl;
        r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.exp[3] = e3; r.exp[4] = e4;
        r.exp_pad = pad; r.exp_gap = gap;
        return r;
    endfunction

    row_t        rows[8];
    logic [15:0] exp_seq;
    logic [31:0] cap[$];
    int          cyc = 0;
    int          pad_cnt;
    int          pad_cyc;
    int          last_xfer;

    always @(posedge bus_clk) cyc++;

    always @(negedge bus_clk) begin
        if (!srst) begin
            if (bus.out_wr_en) cap.push_back(bus.out_din);
            if (bus.in_write && bus.in_full_n) last_xfer = cyc;
            if (pad_event) begin
                pad_cnt++;
                pad_cyc = cyc;
            end
        end
        if (bus.out_full) begin
            chk("no_write_while_full", {31'd0, bus.out_wr_en}, 32'd0);
            chk("no_accept_while_full", {31'd0, bus.in_full_n}, 32'd0);
        end
    end

    task automatic run_row(input int idx, input row_t r);
        int i;
        int stall_left;
        int guard;
        logic [31:0] hdr;
        cap.delete();
        pad_cnt   = 0;
        pad_cyc   = -1;
        last_xfer = -1;
        hdr = {16'hA55A, exp_seq};
        i = 0;
        stall_left = r.stall_len;
        guard = 0;
        while (!(i >= r.n && stall_left == 0) && guard < 300) begin
            @(posedge bus_clk); #1;
            bus.out_full = (i == r.stall_at && stall_left > 0);
            if (bus.out_full) stall_left--;
            bus.in_write = (i < r.n);
            bus.in_din   = (i < r.n) ? r.w[i] : 32'd0;
            #1;
            bus.flush = bus.in_write && (i == r.flush_idx) && bus.in_full_n;
            @(negedge bus_clk);
            if (bus.in_write && bus.in_full_n) i++;
            guard++;
        end
        @(posedge bus_clk); #1;
        bus.in_write = 1'b0;
        bus.flush    = 1'b0;
        bus.out_full = 1'b0;
        while (busy && guard < 300) begin
            @(negedge bus_clk);
            guard++;
        end
        repeat (4) @(negedge bus_clk);
        chk($sformatf("row%0d_done", idx), {31'd0, guard < 300}, 32'd1);
        chk($sformatf("row%0d_words", idx), cap.size(), 32'd6);
        chk($sformatf("row%0d_header", idx), (cap.size() > 0) ? cap[0] : 32'hxxxx_xxxx, hdr);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("row%0d_word%0d", idx, k + 1),
                (cap.size() > k + 1) ? cap[k + 1] : 32'hxxxx_xxxx, r.exp[k]);
        end
        chk($sformatf("row%0d_pad_events", idx), pad_cnt, r.exp_pad);
        if (r.exp_gap > 0) begin
            chk($sformatf("row%0d_pad_delay", idx), pad_cyc - last_xfer, r.exp_gap);
        end
        exp_seq = exp_seq + 16'd1;
        chk($sformatf("row%0d_frame_seq", idx), {16'd0, frame_seq}, {16'd0, exp_seq});
        chk($sformatf("row%0d_busy", idx), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int i;
        int guard;
        rows[0] = mk(4, 32'd1, 32'd2, 32'd3, 32'd4, -1, -1, 0,
                     32'd1, 32'd2, 32'd3, 32'd4, 32'd4, 0, 0);
        rows[1] = mk(1, 32'd5, 32'd0, 32'd0, 32'd0, -1, -1, 0,
                     32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 1, 9);
        rows[2] = mk(2, 32'd10, 32'd20, 32'd0, 32'd0, 1, -1, 0,
                     32'd10, 32'd20, 32'd0, 32'd0, 32'd30, 1, 2);
        rows[3] = mk(4, 32'd1, 32'd2, 32'd4, 32'd8, 3, -1, 0,
                     32'd1, 32'd2, 32'd4, 32'd8, 32'd15, 0, 0);
        rows[4] = mk(1, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 0, -1, 0,
                     32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 1, 2);
        rows[5] = mk(3, 32'hFFFF0000, 32'h0000FFFF, 32'h12345678, 32'd0, -1, -1, 0,
                     32'hFFFF0000, 32'h0000FFFF, 32'h12345678, 32'd0, 32'hEDCBA987, 1, 9);
        rows[6] = mk(4, 32'd1, 32'd2, 32'd3, 32'd4, -1, 2, 6,
                     32'd1, 32'd2, 32'd3, 32'd4, 32'd4, 0, 0);
        rows[7] = mk(2, 32'd7, 32'd9, 32'd0, 32'd0, -1, 2, 10,
                     32'd7, 32'd9, 32'd0, 32'd0, 32'd14, 1, 9);

        srst         = 1'b1;
        bus.in_write = 1'b1;
        bus.in_din   = 32'h7;
        bus.flush    = 1'b0;
        bus.out_full = 1'b0;
        exp_seq      = 16'd0;
        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        chk("reset_out_wr_en", {31'd0, bus.out_wr_en}, 32'd0);
        chk("reset_in_full_n", {31'd0, bus.in_full_n}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_pad_event", {31'd0, pad_event}, 32'd0);
        chk("reset_frame_seq", {16'd0, frame_seq}, 32'd0);
        @(posedge bus_clk); #1;
        srst         = 1'b0;
        bus.in_write = 1'b0;

        for (int k = 0; k < 8; k++) run_row(k, rows[k]);

        // Reset in the middle of a payload.
        cap.delete();
        i = 0;
        guard = 0;
        while (i < 2 && guard < 50) begin
            @(posedge bus_clk); #1;
            bus.in_write = 1'b1;
            bus.in_din   = 32'h100 + i;
            @(negedge bus_clk);
            if (bus.in_full_n) i++;
            guard++;
        end
        @(posedge bus_clk); #1;
        bus.in_din = 32'h999;
        srst       = 1'b1;
        @(negedge bus_clk);
        chk("midreset_out_wr_en", {31'd0, bus.out_wr_en}, 32'd0);
        @(negedge bus_clk);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_frame_seq", {16'd0, frame_seq}, 32'd0);
        chk("midreset_partial_words", cap.size(), 32'd3);
        @(posedge bus_clk); #1;
        srst         = 1'b0;
        bus.in_write = 1'b0;
        exp_seq      = 16'd0;
        run_row(100, rows[0]);

        // Sequence number wrap.
        @(negedge bus_clk);
        force dut.frame_seq_q = 16'hFFFF;
        @(negedge bus_clk);
        release dut.frame_seq_q;
        @(negedge bus_clk);
        chk("wrap_preload", {16'd0, frame_seq}, 32'h0000FFFF);
        exp_seq = 16'hFFFF;
        run_row(200, rows[0]);
        run_row(201, rows[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
